// File: rtl/timer_pkg.sv
// Shared types and constants for the timer sequencer: FSM encoding, mode/direction
// codes and the next-state rule used by timer_ctrl.
package timer_pkg;

    typedef enum logic [1:0] {
        TMR_IDLE = 2'd0,
        TMR_LOAD = 2'd1,
        TMR_RUN  = 2'd2
    } tmr_state_e;

    localparam logic TMR_ONESHOT  = 1'b0;
    localparam logic TMR_PERIODIC = 1'b1;
    localparam logic TMR_UP       = 1'b0;
    localparam logic TMR_DOWN     = 1'b1;

    // stop has priority over everything, including a simultaneous start
    function automatic tmr_state_e tmr_next_state(
        input tmr_state_e state,
        input logic       start,
        input logic       stop,
        input logic       oneshot_end
    );
        tmr_state_e nxt;
        nxt = state;
        if (stop) begin
            nxt = TMR_IDLE;
        end else begin
            case (state)
                TMR_IDLE: nxt = start ? TMR_LOAD : TMR_IDLE;
                TMR_LOAD: nxt = start ? TMR_LOAD : TMR_RUN;
                TMR_RUN: begin
                    if (start) begin
                        nxt = TMR_LOAD;
                    end else if (oneshot_end) begin
                        nxt = TMR_IDLE;
                    end else begin
                        nxt = TMR_RUN;
                    end
                end
                default: nxt = TMR_IDLE;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/counter.sv
// Common up/down counter primitive; priority is clear, then load, then count enable.
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             down_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = down_i ? (cnt_q - WIDTH'(1)) : (cnt_q + WIDTH'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dffr.sv
// Generic register with asynchronous active-low reset to a parameterised value.
module dffr #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_o <= RESET_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable timer sequencer: prescaler plus main counter stepped through
// load/run/terminal phases, producing tick, compare, done pulses and a sticky irq.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PSCR_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  mode_i,
    input  logic                  dir_i,
    input  logic [PSCR_WIDTH-1:0] pscr_i,
    input  logic [DATA_WIDTH-1:0] reload_i,
    input  logic [DATA_WIDTH-1:0] cmp_i,
    input  logic                  irq_clr_i,
    output logic [DATA_WIDTH-1:0] cnt_o,
    output logic                  busy_o,
    output logic                  tick_o,
    output logic                  cmp_o,
    output logic                  done_o,
    output logic                  irq_o
);

    tmr_state_e            state_d;
    tmr_state_e            state_q;
    logic [1:0]            state_bits_q;

    logic                  mode_d,   mode_q;
    logic                  dir_d,    dir_q;
    logic [PSCR_WIDTH-1:0] pscr_d,   pscr_q;
    logic [DATA_WIDTH-1:0] reload_d, reload_q;
    logic [DATA_WIDTH-1:0] cmp_d,    cmp_q;
    logic                  irq_d,    irq_q;

    logic [PSCR_WIDTH-1:0] presc_cnt;
    logic [DATA_WIDTH-1:0] main_cnt;

    logic                  in_load;
    logic                  in_run;
    logic                  cancel;
    logic                  tick;
    logic                  terminal;
    logic                  done;
    logic                  cmp_hit;
    logic                  presc_clr;
    logic                  presc_en;
    logic                  main_load;
    logic                  main_en;
    logic [DATA_WIDTH-1:0] main_load_val;

    always_comb begin
        mode_d   = mode_q;
        dir_d    = dir_q;
        pscr_d   = pscr_q;
        reload_d = reload_q;
        cmp_d    = cmp_q;
        if (start_i) begin
            mode_d   = mode_i;
            dir_d    = dir_i;
            pscr_d   = pscr_i;
            reload_d = reload_i;
            cmp_d    = cmp_i;
        end
    end

    dffr #(.WIDTH(1)) u_mode_reg (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(mode_d), .q_o(mode_q)
    );

    dffr #(.WIDTH(1)) u_dir_reg (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(dir_d), .q_o(dir_q)
    );

    dffr #(.WIDTH(PSCR_WIDTH)) u_pscr_reg (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(pscr_d), .q_o(pscr_q)
    );

    dffr #(.WIDTH(DATA_WIDTH)) u_reload_reg (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(reload_d), .q_o(reload_q)
    );

    dffr #(.WIDTH(DATA_WIDTH)) u_cmp_reg (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(cmp_d), .q_o(cmp_q)
    );

    assign in_load = (state_q == TMR_LOAD);
    assign in_run  = (state_q == TMR_RUN);

    // A start or stop in this cycle cancels any event the counters would produce
    assign cancel   = start_i | stop_i;
    assign tick     = in_run & ~cancel & (presc_cnt == pscr_q);
    assign terminal = (dir_q == TMR_DOWN) ? (main_cnt == '0) : (main_cnt == reload_q);
    assign done     = tick & terminal;
    assign cmp_hit  = tick & (main_cnt == cmp_q);

    assign presc_clr = in_load | tick;
    assign presc_en  = in_run & ~cancel;

    assign main_load_val = (dir_q == TMR_DOWN) ? reload_q : '0;
    assign main_load     = in_load | (done & (mode_q == TMR_PERIODIC));
    assign main_en       = tick & ~terminal;

    counter #(.WIDTH(PSCR_WIDTH)) u_presc_counter (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clr_i      (presc_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (presc_en),
        .down_i     (1'b0),
        .cnt_o      (presc_cnt)
    );

    counter #(.WIDTH(DATA_WIDTH)) u_main_counter (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clr_i      (1'b0),
        .load_i     (main_load),
        .load_val_i (main_load_val),
        .en_i       (main_en),
        .down_i     (dir_q),
        .cnt_o      (main_cnt)
    );

    always_comb begin
        state_d = tmr_next_state(state_q, start_i, stop_i,
                                 done & (mode_q == TMR_ONESHOT));
    end

    dffr #(.WIDTH(2), .RESET_VAL(2'(TMR_IDLE))) u_state_reg (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(state_d), .q_o(state_bits_q)
    );

    assign state_q = tmr_state_e'(state_bits_q);

    // Setting wins over a coincident clear so a terminal count is never lost
    always_comb begin
        irq_d = done | (irq_q & ~irq_clr_i);
    end

    dffr #(.WIDTH(1)) u_irq_reg (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(irq_d), .q_o(irq_q)
    );

    assign cnt_o  = main_cnt;
    assign busy_o = (state_q != TMR_IDLE);
    assign tick_o = tick;
    assign cmp_o  = cmp_hit;
    assign done_o = done;
    assign irq_o  = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: one-shot/periodic, up/down, compare, stop,
// restart, irq set-vs-clear and asynchronous reset, against hand-computed values.
module tb_timer_ctrl;

    localparam int DW = 32;
    localparam int PW = 16;

    localparam int T1_CNT [8] = '{0, 0, 0, 1, 2, 3, 3, 3};
    localparam int T1_BUSY[8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    localparam int T1_TICK[8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    localparam int T1_DONE[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    localparam int T1_IRQ [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    localparam int T2_CNT [6] = '{2, 2, 1, 1, 0, 0};

    logic          clock = 1'b0;
    logic          rstN;
    logic          startPulse;
    logic          stopPulse;
    logic          mode;
    logic          dir;
    logic [PW-1:0] pscr;
    logic [DW-1:0] reload;
    logic [DW-1:0] cmpVal;
    logic          irqClr;
    logic [DW-1:0] cntOut;
    logic          busyOut;
    logic          tickOut;
    logic          cmpOut;
    logic          doneOut;
    logic          irqOut;

    int testCount = 0;
    int failCount = 0;

    always #5 clock = ~clock;

    timer_ctrl #(.DATA_WIDTH(DW), .PSCR_WIDTH(PW)) dut (
        .clk_i     (clock),
        .rst_n_i   (rstN),
        .start_i   (startPulse),
        .stop_i    (stopPulse),
        .mode_i    (mode),
        .dir_i     (dir),
        .pscr_i    (pscr),
        .reload_i  (reload),
        .cmp_i     (cmpVal),
        .irq_clr_i (irqClr),
        .cnt_o     (cntOut),
        .busy_o    (busyOut),
        .tick_o    (tickOut),
        .cmp_o     (cmpOut),
        .done_o    (doneOut),
        .irq_o     (irqOut)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkCycle(input string tag, input int cntExp, input int busyExp,
                              input int tickExp, input int cmpExp, input int doneExp);
        checkOutput({tag, ".cnt"},  32'(cntOut),  32'(cntExp));
        checkOutput({tag, ".busy"}, 32'(busyOut), 32'(busyExp));
        checkOutput({tag, ".tick"}, 32'(tickOut), 32'(tickExp));
        checkOutput({tag, ".cmp"},  32'(cmpOut),  32'(cmpExp));
        checkOutput({tag, ".done"}, 32'(doneOut), 32'(doneExp));
    endtask

    // Moves to just after the next rising edge and drops all one-cycle pulses
    task automatic advance();
        @(posedge clock);
        #1;
        startPulse = 1'b0;
        stopPulse  = 1'b0;
        irqClr     = 1'b0;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // Leaves the bench in "cycle 0" with start_i asserted and the config applied
    task automatic applyStimulus(input logic m, input logic d, input logic [PW-1:0] p,
                                 input logic [DW-1:0] r, input logic [DW-1:0] c);
        advance();
        mode       = m;
        dir        = d;
        pscr       = p;
        reload     = r;
        cmpVal     = c;
        startPulse = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected it to");
        $fatal(1);
    end

    initial begin
        int k;
        int cmpSeen;

        rstN       = 1'b0;
        startPulse = 1'b0;
        stopPulse  = 1'b0;
        mode       = 1'b0;
        dir        = 1'b0;
        pscr       = '0;
        reload     = '0;
        cmpVal     = '0;
        irqClr     = 1'b0;

        #12;
        checkCycle("reset", 0, 0, 0, 0, 0);
        checkOutput("reset.irq", 32'(irqOut), 32'd0);
        sample();
        rstN = 1'b1;

        // 1: up, one-shot, pscr=0, reload=3; inputs scrambled after start must be ignored
        applyStimulus(1'b0, 1'b0, 16'd0, 32'd3, 32'd100);
        for (int c = 0; c < 8; c++) begin
            sample();
            checkCycle($sformatf("t1.c%0d", c), T1_CNT[c], T1_BUSY[c], T1_TICK[c], 0, T1_DONE[c]);
            checkOutput($sformatf("t1.c%0d.irq", c), 32'(irqOut), 32'(T1_IRQ[c]));
            advance();
            if (c == 0) begin
                reload = 32'd50;
                mode   = 1'b1;
                pscr   = 16'd4;
            end
        end

        // 2: down, periodic, pscr=1, reload=2
        applyStimulus(1'b1, 1'b1, 16'd1, 32'd2, 32'd100);
        for (int c = 0; c < 15; c++) begin
            sample();
            if (c >= 2) begin
                k = c - 2;
                checkCycle($sformatf("t2.c%0d", c), T2_CNT[k % 6], 1,
                           (k % 2 == 1) ? 1 : 0, 0, (k % 6 == 5) ? 1 : 0);
            end
            advance();
        end
        stopPulse = 1'b1;
        sample();
        checkCycle("t2.stop", 2, 1, 0, 0, 0);
        advance();
        sample();
        checkCycle("t2.idle", 2, 0, 0, 0, 0);

        // 3: up, periodic, pscr=0, reload=9, cmp=4
        cmpSeen = 0;
        applyStimulus(1'b1, 1'b0, 16'd0, 32'd9, 32'd4);
        for (int c = 0; c < 22; c++) begin
            sample();
            if (c >= 2) begin
                k = c - 2;
                checkCycle($sformatf("t3.c%0d", c), k % 10, 1, 1,
                           (k % 10 == 4) ? 1 : 0, (k % 10 == 9) ? 1 : 0);
                if (cmpOut) cmpSeen++;
            end
            advance();
        end
        checkOutput("t3.cmpCount", 32'(cmpSeen), 32'd2);
        stopPulse = 1'b1;

        // 4: stop mid-run at cnt=5 with irq cleared beforehand
        advance();
        irqClr = 1'b1;
        advance();
        sample();
        checkOutput("t4.irqCleared", 32'(irqOut), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'd0, 32'd9, 32'd100);
        for (int c = 0; c < 7; c++) begin
            sample();
            advance();
        end
        stopPulse = 1'b1;
        sample();
        checkCycle("t4.stopCycle", 5, 1, 0, 0, 0);
        advance();
        sample();
        checkCycle("t4.afterStop", 5, 0, 0, 0, 0);
        checkOutput("t4.irq", 32'(irqOut), 32'd0);
        advance();
        sample();
        checkCycle("t4.hold", 5, 0, 0, 0, 0);
        advance();
        startPulse = 1'b1;
        stopPulse  = 1'b1;
        reload     = 32'd20;
        sample();
        advance();
        sample();
        checkCycle("t4.startStop", 5, 0, 0, 0, 0);

        // 5a: irq_clr coincident with done leaves irq set
        applyStimulus(1'b0, 1'b0, 16'd0, 32'd1, 32'd100);
        for (int c = 0; c < 3; c++) begin
            sample();
            advance();
        end
        irqClr = 1'b1;
        sample();
        checkCycle("t5.doneCycle", 1, 1, 1, 0, 1);
        advance();
        sample();
        checkOutput("t5.irqSetWins", 32'(irqOut), 32'd1);
        checkOutput("t5.oneshotIdle", 32'(busyOut), 32'd0);

        // 5b: restart during RUN with a new down-count config
        applyStimulus(1'b1, 1'b0, 16'd0, 32'd9, 32'd100);
        for (int c = 0; c < 5; c++) begin
            sample();
            advance();
        end
        dir        = 1'b1;
        reload     = 32'd6;
        startPulse = 1'b1;
        sample();
        checkCycle("t5.restartCycle", 3, 1, 0, 0, 0);
        advance();
        sample();
        checkCycle("t5.reload", 3, 1, 0, 0, 0);
        advance();
        sample();
        checkCycle("t5.firstRun", 6, 1, 1, 0, 0);
        advance();
        sample();
        checkCycle("t5.step", 5, 1, 1, 0, 0);
        advance();
        stopPulse = 1'b1;
        advance();

        // 6: asynchronous reset mid-run, pscr=7
        applyStimulus(1'b1, 1'b0, 16'd7, 32'd5, 32'd100);
        for (int c = 0; c < 13; c++) begin
            sample();
            if (c == 12) checkCycle("t6.preReset", 1, 1, 0, 0, 0);
            advance();
        end
        #2;
        rstN = 1'b0;
        #1;
        checkCycle("t6.inReset", 0, 0, 0, 0, 0);
        checkOutput("t6.inReset.irq", 32'(irqOut), 32'd0);
        sample();
        rstN = 1'b1;
        advance();
        sample();
        checkCycle("t6.released", 0, 0, 0, 0, 0);
        advance();
        sample();
        checkOutput("t6.stillIdle", 32'(busyOut), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
